serial_frame_rx: RTL and testbench
==================================

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data bits per frame (legal range 2..16).
REQ-002 The block SHALL have parameter PARITY_EN, default 1: 1 means an even-parity bit follows the data, 0 means there is no parity bit.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port d, input, 1 bit: serial line, one bit per clock, driven from the upstream registered (dff) stage; idles high.
REQ-006 The block SHALL have port data, output, WIDTH bits: the last correctly received word.
REQ-007 The block SHALL have port valid, output, 1 bit: one-cycle pulse, data updated.
REQ-008 The block SHALL have port parity_err, output, 1 bit: one-cycle pulse, parity mismatch.
REQ-009 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse, stop bit was 0.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-011 The block SHALL have port frame_count, output, 8 bits: count of good frames.

Function
REQ-012 Frame format SHALL be: start bit 0; WIDTH data bits, LSB first; parity bit if PARITY_EN; stop bit 1.
REQ-013 The block SHALL have states IDLE, DATA, PARITY, STOP and RECOVER, each lasting one bit per clock with no oversampling.
REQ-014 IDLE: on an edge sampling d=0 the block SHALL clear the bit counter and go to DATA; on d=1 it SHALL stay in IDLE.
REQ-015 DATA: each edge SHALL shift d into the word at bit position equal to the counter; after the WIDTH-th bit the block SHALL go to PARITY if PARITY_EN, else to STOP.
REQ-016 PARITY: the block SHALL sample d; even parity SHALL hold when the XOR of the data bits and the parity bit is 0; the block then SHALL go to STOP.
REQ-017 STOP, d=1 with parity OK (or PARITY_EN=0): data SHALL load the word, valid=1, frame_count increments, and the block SHALL go to IDLE.
REQ-018 STOP, d=1 with parity bad: parity_err=1; data and frame_count SHALL stay unchanged; the block SHALL go to IDLE.
REQ-019 STOP, d=0: frame_err=1, and parity_err also asserts if parity is bad; data and frame_count SHALL stay unchanged; the block SHALL go to RECOVER.
REQ-020 RECOVER: the block SHALL stay while d=0 (line break, not a start) and go to IDLE on an edge sampling d=1.
REQ-021 valid, parity_err and frame_err SHALL each be registered and high for exactly the one cycle after the STOP edge; they SHALL be 0 at all other times.
REQ-022 Latency: with the start sampled at edge E0, the stop SHALL be sampled at edge E(WIDTH+1+PARITY_EN), and the pulses SHALL be visible in the cycle that follows.
REQ-023 Back-to-back frames SHALL be supported: a start sampled at the edge immediately after a good or parity-bad STOP edge SHALL be accepted, giving a minimum frame period of WIDTH+2+PARITY_EN cycles.
REQ-024 frame_count SHALL wrap from 255 to 0.
REQ-025 data SHALL hold its value between good frames.

Reset
REQ-026 The block SHALL treat rst=1 at a rising edge as taking precedence over all other inputs.
REQ-027 On reset the block SHALL go to IDLE and set data=0, valid=0, parity_err=0, frame_err=0, busy=0, frame_count=0, with the bit counter and shift register cleared.
REQ-028 On a reset mid-frame the block SHALL discard the partial frame and assert no pulse.
REQ-029 On the first edge after rst falls, the block SHALL treat d=0 as a start bit.

Verification (WIDTH=8, PARITY_EN=1)
REQ-030 Reset: rst=1 for 2 cycles with all outputs forced nonzero beforehand -> all outputs 0 and busy=0.
REQ-031 Good frame 0xA5: d=0; then 1,0,1,0,0,1,0,1; parity 0; stop 1 -> valid high for one cycle after E10, data=8'hA5, frame_count=1, busy low from the cycle after E10.
REQ-032 Parity error: 0x01 sent with parity 0, stop 1 -> parity_err for one cycle, valid=0, data stays 8'hA5, frame_count unchanged.
REQ-033 Framing error: 0x3C with a good parity bit, stop 0, then d=0 for 3 more cycles, then d=1 -> frame_err for one cycle, busy=1 through RECOVER, IDLE one edge after d=1, no false start.
REQ-034 Back-to-back: 0x3C then 0xFF with no idle bit between them -> two valid pulses 11 cycles apart, data=8'h3C then 8'hFF.
REQ-035 Mid-frame reset: rst=1 after 4 data bits, then a full 0x5A frame -> no pulse from the aborted frame, then valid with data=8'h5A.
REQ-036 Wrap: 256 good frames -> frame_count returns to 0.

Source files
------------

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: one bit per clock, start/data(LSB first)/optional even parity/stop.
// Reports good words, parity errors and framing errors as one-cycle registered pulses.
`timescale 1ns/1ps
module serial_frame_rx #(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             busy,
    output logic [7:0]       frame_count
);

    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, RECOVER} state_t;

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             par_acc;
    logic             parity_ok;
    logic             valid_nx, perr_nx, ferr_nx;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: default assignment first so no path through the case leaves state_nx unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!d) state_nx = DATA;
            DATA:    if (cnt == CW'(WIDTH - 1)) state_nx = PARITY_EN ? PARITY : STOP;
            PARITY:  state_nx = STOP;
            STOP:    state_nx = d ? IDLE : RECOVER;
            RECOVER: if (d) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // par_acc holds XOR of data bits and the parity bit, so zero means even parity held.
    always_comb begin
        parity_ok = PARITY_EN ? ~par_acc : 1'b1;
        valid_nx  = 1'b0;
        perr_nx   = 1'b0;
        ferr_nx   = 1'b0;
        if (state == STOP) begin
            valid_nx = d & parity_ok;
            perr_nx  = ~parity_ok;
            ferr_nx  = ~d;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            shreg       <= '0;
            par_acc     <= 1'b0;
            data        <= '0;
            valid       <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            valid      <= valid_nx;
            parity_err <= perr_nx;
            frame_err  <= ferr_nx;
            case (state)
                IDLE: begin
                    if (!d) begin
                        cnt     <= '0;
                        par_acc <= 1'b0;
                    end
                end
                DATA: begin
                    shreg[cnt] <= d;
                    cnt        <= cnt + CW'(1);
                    par_acc    <= par_acc ^ d;
                end
                PARITY:  par_acc <= par_acc ^ d;
                default: ;
            endcase
            if (valid_nx) begin
                data        <= shreg;
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx (WIDTH=8, PARITY_EN=1): stimulus pushes expected
// pulses and state probes into queues; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d   = 1'b1;
    logic [7:0] data;
    logic       valid, parity_err, frame_err, busy;
    logic [7:0] frame_count;

    serial_frame_rx #(.WIDTH(8), .PARITY_EN(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .d           (d),
        .data        (data),
        .valid       (valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [2:0]  pulses;   // {valid, parity_err, frame_err}
        logic [7:0]  data;
        logic [7:0]  count;
        logic        busy;
    } exp_t;

    exp_t ev_q[$];
    exp_t pr_q[$];
    logic [7:0] m_data  = 8'd0;
    logic [7:0] m_count = 8'd0;
    bit         done    = 1'b0;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Each drive presents one bit and returns #1 after the edge that sampled it.
    task automatic drive(input logic b);
        rst = 1'b0;
        d   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input logic [2:0] pulses, input logic bsy);
        exp_t e;
        e.cyc = cyc; e.pulses = pulses; e.data = m_data; e.count = m_count; e.busy = bsy;
        pr_q.push_back(e);
    endtask

    task automatic reset_cycles(input int n);
        rst = 1'b1;
        d   = 1'b1;
        m_data  = 8'd0;
        m_count = 8'd0;
        repeat (n) begin
            @(posedge clk);
            #1;
            probe(3'b000, 1'b0);
        end
    endtask

    task automatic send_frame(input logic [7:0] w, input logic par_bad, input logic stop);
        exp_t e;
        logic ok;
        drive(1'b0);
        for (int i = 0; i < 8; i++) drive(w[i]);
        drive((^w) ^ par_bad);
        drive(stop);
        ok = !par_bad;
        if (stop && ok) begin
            m_data  = w;
            m_count = m_count + 8'd1;
        end
        e.cyc = cyc; e.pulses = {stop & ok, !ok, !stop};
        e.data = m_data; e.count = m_count; e.busy = !stop;
        ev_q.push_back(e);
    endtask

    initial begin
        @(posedge clk);
        #1;
        reset_cycles(2);
        // Put nonzero values on every output, then reset while valid is high.
        send_frame(8'h77, 1'b0, 1'b1);
        reset_cycles(2);
        // Good frame 0xA5, then idle.
        send_frame(8'hA5, 1'b0, 1'b1);
        drive(1'b1); probe(3'b000, 1'b0);
        // Parity error on 0x01.
        send_frame(8'h01, 1'b1, 1'b1);
        drive(1'b1); probe(3'b000, 1'b0);
        // Framing error on 0x3C, line held low through RECOVER.
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (3) begin drive(1'b0); probe(3'b000, 1'b1); end
        drive(1'b1); probe(3'b000, 1'b0);
        drive(1'b1); probe(3'b000, 1'b0);
        // Framing and parity error together.
        send_frame(8'h81, 1'b1, 1'b0);
        drive(1'b1); probe(3'b000, 1'b0);
        // Back-to-back frames.
        send_frame(8'h3C, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        drive(1'b1);
        // Mid-frame reset after 4 data bits of 0x5A, then a full 0x5A.
        drive(1'b0);
        drive(1'b0); drive(1'b1); drive(1'b0); drive(1'b1);
        reset_cycles(1);
        send_frame(8'h5A, 1'b0, 1'b1);
        drive(1'b1); probe(3'b000, 1'b0);
        // 256 good frames wrap frame_count back to 0.
        reset_cycles(1);
        for (int i = 0; i < 256; i++) send_frame(8'(i) ^ 8'h3C, 1'b0, 1'b1);
        drive(1'b1); probe(3'b000, 1'b0);
        repeat (3) drive(1'b1);
        done = 1'b1;
    end

    exp_t mon_e;
    always @(negedge clk) begin
        if (done) begin
            check("events_left", 32'(ev_q.size()), 0);
            check("probes_left", 32'(pr_q.size()), 0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end else begin
            while (pr_q.size() > 0 && pr_q[0].cyc < cyc) begin
                mon_e = pr_q.pop_front();
                check("probe_missed", cyc, mon_e.cyc);
            end
            if (pr_q.size() > 0 && pr_q[0].cyc == cyc) begin
                mon_e = pr_q.pop_front();
                check("probe_pulses", 32'({valid, parity_err, frame_err}), 32'(mon_e.pulses));
                check("probe_busy",   32'(busy),        32'(mon_e.busy));
                check("probe_data",   32'(data),        32'(mon_e.data));
                check("probe_count",  32'(frame_count), 32'(mon_e.count));
            end
            if ({valid, parity_err, frame_err} != 3'b000) begin
                if (ev_q.size() == 0) begin
                    check("unexpected_pulse", 32'({valid, parity_err, frame_err}), 0);
                end else begin
                    mon_e = ev_q.pop_front();
                    check("pulse_cycle",  cyc, mon_e.cyc);
                    check("pulse_kind",   32'({valid, parity_err, frame_err}), 32'(mon_e.pulses));
                    check("pulse_data",   32'(data),        32'(mon_e.data));
                    check("pulse_count",  32'(frame_count), 32'(mon_e.count));
                    check("pulse_busy",   32'(busy),        32'(mon_e.busy));
                end
            end else if (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
                mon_e = ev_q.pop_front();
                check("pulse_missing", 0, 32'(mon_e.pulses));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
